adder_tree_feeder: RTL



---
 rtl/adder_tree_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: packs NUM signed operands, received one per beat on a
// valid/ready stream, into a single NUM*IN_WIDTH vector for the adder tree.
// Slot 0 (first operand) sits in the most significant lane.
// The output register decouples tree-side stalls from the producer. A
// complete buffer that cannot be handed over waits in PEND (cnt==NUM).
// Optional feature macro: ADDER_TREE_FEEDER_FLUSH_EN adds in_last, which
// closes a vector early. The unfilled slots are driven as zero.
module adder_tree_feeder #(
    parameter int IN_WIDTH = 8,
    parameter int NUM      = 4,
    localparam int CNT_W   = $clog2(NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IN_WIDTH-1:0]   in_data,
`ifdef ADDER_TREE_FEEDER_FLUSH_EN
    input  logic                         in_last,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM*IN_WIDTH-1:0]      out_data,
    output logic [CNT_W-1:0]             fill_cnt
);

    localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM - 1);

    // Slot k occupies bits [(NUM-k)*IN_WIDTH-1 -: IN_WIDTH]
    function automatic logic [NUM*IN_WIDTH-1:0] pack_slots(
        input logic signed [IN_WIDTH-1:0] s [NUM]
    );
        logic [NUM*IN_WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < NUM; k++) begin
            v[(NUM-k)*IN_WIDTH-1 -: IN_WIDTH] = s[k];
        end
        return v;
    endfunction

    logic signed [IN_WIDTH-1:0] fill_p0 [NUM];
    logic signed [IN_WIDTH-1:0] merged  [NUM];
    logic [CNT_W-1:0]           cnt;

    logic                       in_acc;
    logic                       out_acc;
    logic                       out_free;
    logic                       last_beat;
    logic                       done_in;
    logic                       drain_pend;
    logic                       load_out;
    logic                       park;
    logic [NUM*IN_WIDTH-1:0]    out_next;

    // in_ready depends only on the fill count, never on out_ready
    assign in_ready = (cnt < NUM_C);
    assign fill_cnt = cnt;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

`ifdef ADDER_TREE_FEEDER_FLUSH_EN
    assign last_beat = (cnt == LAST_C) || in_last;
`else
    assign last_beat = (cnt == LAST_C);
`endif

    // Buffer contents with the incoming operand dropped into slot cnt
    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            merged[k] = fill_p0[k];
            if (CNT_W'(k) == cnt) begin
                merged[k] = in_data;
            end
        end
    end

    // Decode which of completion, parking or PEND drain happens this cycle
    always_comb begin
        done_in    = in_acc && last_beat;
        drain_pend = (cnt == NUM_C) && out_acc;
        load_out   = drain_pend || (done_in && out_free);
        park       = done_in && !out_free;
        out_next   = drain_pend ? pack_slots(fill_p0) : pack_slots(merged);
    end

    // Control stage: fill count and output valid
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load_out) begin
                cnt <= '0;
            end else if (park) begin
                cnt <= NUM_C;
            end else if (in_acc) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (load_out) begin
                out_valid <= 1'b1;
            end else if (out_acc) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Data stage: fill buffer slots; emptied whenever a vector leaves it so
    // an early-closed vector carries zeros in its unused slots
    always_ff @(posedge clk) begin
        if (rst || load_out) begin
            for (int k = 0; k < NUM; k++) begin
                fill_p0[k] <= '0;
            end
        end else if (in_acc) begin
            for (int k = 0; k < NUM; k++) begin
                if (CNT_W'(k) == cnt) begin
                    fill_p0[k] <= in_data;
                end
            end
        end
    end

    // Output register: loaded only when a vector is handed over, otherwise
    // held so it stays stable under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (load_out) begin
            out_data <= out_next;
        end
    end

endmodule
